seq_gates_oai_pipe: RTL and testbench
=====================================

# seq_gates_oai_pipe

Parametrised, pipelined successor to the single-bit OAI22 gate problem. Evaluates a bitwise OR-AND-INVERT (or AOI/OA/AO, selected per transaction) over NTERMS groups of TERM_IN vectors, each NBITS wide. Results pass through a two-stage valid/ready pipeline with full backpressure and a saturating transfer counter. It is the sequential, multi-channel gate block in the combinational-gates problem family.

## Interface
- NBITS, 4, width of every operand vector and of the result
- NTERMS, 2, number of first-level terms (2..8)
- TERM_IN, 2, operands per term (2..8)
- CNT_BITS, 8, width of the transfer counter
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low; 0 clears all state immediately, independent of clk
- in_val  input  1  input transaction valid
- in_rdy  output  1  block can accept input this cycle
- in_mode  input  2  00 OAI, 01 AOI, 10 OA, 11 AO
- in_data  input  NTERMS*TERM_IN*NBITS  operand t,k at bits [(t*TERM_IN+k)*NBITS +: NBITS]
- out_val  output  1  result valid
- out_rdy  input  1  consumer accepts result this cycle
- out_data  output  NBITS  result
- xfer_count  output  CNT_BITS  number of accepted outputs, saturating

## Operation
- Stage 1 (on input accept): per term t, term_t = bitwise OR of its TERM_IN operands for modes 00/10, bitwise AND for modes 01/11. Register term vectors, mode, s1_val.
- Stage 2: combine terms with bitwise AND for modes 00/10, bitwise OR for modes 01/11. Invert for modes 00/01; pass through for 10/11. Register into out_data, set s2_val.
- Mode travels with its data; changing in_mode while a transaction is in flight never affects it.
- Defaults with NBITS=1: out = ~((in0|in1)&(in2|in3)), operands ordered in0..in3 from bit 0.
- out_val = s2_val. Output transfer: out_val & out_rdy.
- s2 loads when s1_val and (!s2_val or out_rdy). s2_val clears on output transfer with no s1 load.
- in_rdy = !s1_val or s2 loading (combinational from out_rdy). s1 loads on in_val & in_rdy.
- Simultaneous input accept and s1-to-s2 move: both occur, no bubble.
- xfer_count increments on each output transfer; holds at 2^CNT_BITS-1, never wraps.
- out_data holds its value while out_val & !out_rdy; it is unchanged when out_val is 0 (last result or reset value).
- in_val=0: in_data/in_mode ignored, no state change in stage 1.

## Timing
- Reset asserted (reset=0): s1_val=0, s2_val=0, out_val=0, out_data=0, xfer_count=0, in_rdy=1 (once state is clear). Deasserting reset has effect at the next rising edge; reset mid-transaction discards all in-flight data.
- Latency: input accepted at edge k produces out_val=1 in the cycle after edge k+1 (2 cycles).
- Throughput: one transaction per cycle while out_rdy=1.
- Backpressure: with out_rdy=0 the pipe holds 2 transactions; in_rdy=0 once both stages are full; no data lost or duplicated.
- out_rdy rising while full: out transfer, s1→s2, and new input accept all at the same edge.

## Test plan
- Exhaustive defaults, NBITS=1, mode 00: all 16 in_data values 0x0..0xF with out_rdy=1 → out matches ~((b0|b1)&(b2|b3)), e.g. 0x0→1, 0x5→0, 0xC→1; each result 2 cycles after accept, one per cycle.
- Modes, NBITS=4: in_data=0x00F0 with modes 00,01,10,11 back to back → out_data 0xF, 0xF, 0x0, 0x0 in order; in_data=0xFFFF → 0x0, 0x0, 0xF, 0xF.
- Backpressure: stream 4 transactions, hold out_rdy=0 → in_rdy drops after 2 accepted, out_data stable; release out_rdy → all 4 emerge in order, no gaps, xfer_count=4.
- Reset mid-flight: 2 transactions in pipe, drive reset=0 between edges → out_val=0, out_data=0, xfer_count=0 immediately; after release, next input emerges with correct value.
- Counter saturation, CNT_BITS=3: 10 output transfers → xfer_count reads 7 and stays 7.
- Wide config NTERMS=3, TERM_IN=3, NBITS=2: one operand per term =0b11, rest 0, mode 00 → out_data 0b00; clear term 2's operand → 0b11.

Source files
------------

// File: rtl/seq_gates_oai_pipe.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : seq_gates_oai_pipe
// Brief   : Two-stage valid/ready pipelined OAI/AOI/OA/AO gate over NBITS
//           lanes with a saturating output-transfer counter.
// Revision: 1.0  initial release
// ============================================================================
module seq_gates_oai_pipe #(
  parameter int NBITS    = 4,
  parameter int NTERMS   = 2,
  parameter int TERM_IN  = 2,
  parameter int CNT_BITS = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             in_val,
  output logic                             in_rdy,
  input  logic [1:0]                       in_mode,
  input  logic [NTERMS*TERM_IN*NBITS-1:0]  in_data,
  output logic                             out_val,
  input  logic                             out_rdy,
  output logic [NBITS-1:0]                 out_data,
  output logic [CNT_BITS-1:0]              xfer_count
);

  logic [NTERMS-1:0][NBITS-1:0] w_terms;
  logic [NTERMS-1:0][NBITS-1:0] r_terms;
  logic [1:0]                   r_mode;
  logic                         r_s1_val;
  logic                         r_s2_val;
  logic [NBITS-1:0]             r_out;
  logic [CNT_BITS-1:0]          r_cnt;
  logic [NBITS-1:0]             w_comb;
  logic [NBITS-1:0]             w_result;
  logic                         w_out_xfer;
  logic                         w_s2_load;
  logic                         w_s1_load;

  // mode[0] selects AND for the first level and OR for the second level
  always_comb begin
    for (int t = 0; t < NTERMS; t++) begin
      w_terms[t] = {NBITS{in_mode[0]}};
      for (int k = 0; k < TERM_IN; k++) begin
        if (in_mode[0])
          w_terms[t] = w_terms[t] & in_data[(t*TERM_IN+k)*NBITS +: NBITS];
        else
          w_terms[t] = w_terms[t] | in_data[(t*TERM_IN+k)*NBITS +: NBITS];
      end
    end
  end

  // mode[1] set means no final inversion
  always_comb begin
    w_comb = {NBITS{~r_mode[0]}};
    for (int t = 0; t < NTERMS; t++) begin
      if (r_mode[0])
        w_comb = w_comb | r_terms[t];
      else
        w_comb = w_comb & r_terms[t];
    end
    w_result = r_mode[1] ? w_comb : ~w_comb;
  end

  assign w_out_xfer = r_s2_val & out_rdy;
  assign w_s2_load  = r_s1_val & (~r_s2_val | out_rdy);
  assign in_rdy     = ~r_s1_val | w_s2_load;
  assign w_s1_load  = in_val & in_rdy;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_terms  <= '0;
      r_mode   <= 2'b00;
      r_s1_val <= 1'b0;
      r_s2_val <= 1'b0;
      r_out    <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_s1_load) begin
        r_terms <= w_terms;
        r_mode  <= in_mode;
      end

      if (w_s1_load)
        r_s1_val <= 1'b1;
      else if (w_s2_load)
        r_s1_val <= 1'b0;

      if (w_s2_load) begin
        r_out    <= w_result;
        r_s2_val <= 1'b1;
      end else if (w_out_xfer) begin
        r_s2_val <= 1'b0;
      end

      if (w_out_xfer && (r_cnt != {CNT_BITS{1'b1}}))
        r_cnt <= r_cnt + 1'b1;
    end
  end

  assign out_val    = r_s2_val;
  assign out_data   = r_out;
  assign xfer_count = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_seq_gates_oai_pipe.sv
`default_nettype none
`timescale 1ns/1ps
// Bench for seq_gates_oai_pipe: three configurations checked every cycle
// against a count-based gate model and an item-queue pipeline model.
module tb_seq_gates_oai_pipe;

  typedef struct {
    int       stamp;
    bit       lit_en;
    bit [7:0] lit;
    bit [7:0] val;
  } item_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic        ival [3];
  logic        ordy [3];
  logic [1:0]  mode [3];
  logic [17:0] din  [3];
  bit          lit_en [3];
  bit   [7:0]  lit    [3];

  logic        irdy [3];
  logic        oval [3];
  logic [7:0]  od   [3];
  logic [7:0]  cnt  [3];
  logic [0:0]  od0;
  logic [3:0]  od1;
  logic [1:0]  od2;
  logic [7:0]  cnt0;
  logic [2:0]  cnt1;
  logic [7:0]  cnt2;

  int total = 0;
  int bad   = 0;

  // cfg0: NBITS=1 defaults; cfg1: NBITS=4, CNT_BITS=3; cfg2: 3x3 terms, NBITS=2
  seq_gates_oai_pipe #(.NBITS(1), .NTERMS(2), .TERM_IN(2), .CNT_BITS(8)) u_dut0 (
    .clk(clk), .reset(reset), .in_val(ival[0]), .in_rdy(irdy[0]), .in_mode(mode[0]),
    .in_data(din[0][3:0]), .out_val(oval[0]), .out_rdy(ordy[0]), .out_data(od0),
    .xfer_count(cnt0));
  seq_gates_oai_pipe #(.NBITS(4), .NTERMS(2), .TERM_IN(2), .CNT_BITS(3)) u_dut1 (
    .clk(clk), .reset(reset), .in_val(ival[1]), .in_rdy(irdy[1]), .in_mode(mode[1]),
    .in_data(din[1][15:0]), .out_val(oval[1]), .out_rdy(ordy[1]), .out_data(od1),
    .xfer_count(cnt1));
  seq_gates_oai_pipe #(.NBITS(2), .NTERMS(3), .TERM_IN(3), .CNT_BITS(8)) u_dut2 (
    .clk(clk), .reset(reset), .in_val(ival[2]), .in_rdy(irdy[2]), .in_mode(mode[2]),
    .in_data(din[2][17:0]), .out_val(oval[2]), .out_rdy(ordy[2]), .out_data(od2),
    .xfer_count(cnt2));

  assign od[0]  = {7'd0, od0};
  assign od[1]  = {4'd0, od1};
  assign od[2]  = {6'd0, od2};
  assign cnt[0] = cnt0;
  assign cnt[1] = {5'd0, cnt1};
  assign cnt[2] = cnt2;

  function automatic int nb_of(int i);
    return (i == 0) ? 1 : ((i == 1) ? 4 : 2);
  endfunction
  function automatic int nt_of(int i);
    return (i == 2) ? 3 : 2;
  endfunction
  function automatic int cmax_of(int i);
    return (i == 1) ? 7 : 255;
  endfunction

  // A term is true when any (OR) or all (AND) of its operand bits are set.
  function automatic bit [7:0] model(logic [17:0] d, logic [1:0] m, int i);
    bit [7:0] r;
    int nb;
    int nt;
    r  = 8'd0;
    nb = nb_of(i);
    nt = nt_of(i);
    for (int b = 0; b < nb; b++) begin
      int  tt;
      bit  comb;
      tt = 0;
      for (int t = 0; t < nt; t++) begin
        int ones;
        ones = 0;
        for (int k = 0; k < nt; k++)
          if (d[(t*nt+k)*nb+b]) ones++;
        if (m[0] ? (ones == nt) : (ones > 0)) tt++;
      end
      comb = m[0] ? (tt > 0) : (tt == nt);
      r[b] = m[1] ? comb : !comb;
    end
    return r;
  endfunction

  item_t    q [3][$];
  int       cyc = 0;
  int       acc_cnt [3];
  bit [7:0] mlast [3];
  int       mcnt [3];

  function automatic bit head_ready(int i);
    if (q[i].size() == 0) return 1'b0;
    return (cyc - q[i][0].stamp) >= 1;
  endfunction

  // Pipeline model: an item is visible at the output from the cycle after the
  // edge following its acceptance, and only while it is at the queue head.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 3; i++) begin
        q[i].delete();
        mlast[i] <= 8'd0;
        mcnt[i]  <= 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        bit    ov;
        bit    ir;
        item_t h;
        item_t n;
        ov = head_ready(i);
        ir = (q[i].size() < 2) || ordy[i];
        if (ov && ordy[i]) begin
          h = q[i].pop_front();
          mlast[i] <= h.val;
          if (mcnt[i] < cmax_of(i)) mcnt[i] <= mcnt[i] + 1;
        end
        if (ival[i] && ir) begin
          n.stamp  = cyc + 1;
          n.lit_en = lit_en[i];
          n.lit    = lit[i];
          n.val    = model(din[i], mode[i], i);
          q[i].push_back(n);
          acc_cnt[i] <= acc_cnt[i] + 1;
        end
      end
      cyc <= cyc + 1;
    end
  end

  task automatic chk(string name, int i, logic [7:0] act, logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cfg%0d cyc%0d: got %0h want %0h", name, i, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      bit ov;
      ov = head_ready(i);
      chk("in_rdy", i, {7'd0, irdy[i]}, {7'd0, (q[i].size() < 2) || ordy[i]});
      chk("out_val", i, {7'd0, oval[i]}, {7'd0, ov});
      chk("xfer_count", i, cnt[i], 8'(mcnt[i]));
      chk("out_data", i, od[i], ov ? q[i][0].val : mlast[i]);
      if (ov && q[i][0].lit_en)
        chk("out_data_literal", i, od[i], q[i][0].lit);
    end
  end

  task automatic send(int i, logic [17:0] d, logic [1:0] m, bit [7:0] l);
    int start;
    int n;
    ival[i]   = 1'b1;
    din[i]    = d;
    mode[i]   = m;
    lit_en[i] = 1'b1;
    lit[i]    = l;
    start     = acc_cnt[i];
    n         = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (acc_cnt[i] == start && n < 40);
    if (acc_cnt[i] == start) begin
      $display("FAIL accept_timeout cfg%0d: got no accept want accept", i);
      $fatal(1);
    end
  endtask

  task automatic idle(int i);
    ival[i]   = 1'b0;
    lit_en[i] = 1'b0;
    din[i]    = 18'h2A5A5;
    mode[i]   = 2'b11;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q[0].size() + q[1].size() + q[2].size()) > 0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    #1;
    if ((q[0].size() + q[1].size() + q[2].size()) > 0) begin
      $display("FAIL drain_timeout: got %0d items want 0", q[0].size() + q[1].size() + q[2].size());
      $fatal(1);
    end
  endtask

  bit [15:0] oai_tbl = 16'h111F;
  bit [17:0] bp_d [4] = '{18'h0F0F, 18'h3C21, 18'h00F0, 18'h1248};
  bit [7:0]  bp_l [4] = '{8'h0, 8'hC, 8'hF, 8'hF};
  bit [7:0]  m0_l [4] = '{8'hF, 8'hF, 8'h0, 8'h0};
  bit [7:0]  m1_l [4] = '{8'h0, 8'h0, 8'hF, 8'hF};

  initial begin
    for (int i = 0; i < 3; i++) begin
      ival[i] = 1'b0; ordy[i] = 1'b1; mode[i] = 2'b00; din[i] = '0;
      lit_en[i] = 1'b0; lit[i] = 8'd0;
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;

    for (int v = 0; v < 16; v++)
      send(0, 18'(v), 2'b00, {7'd0, oai_tbl[v]});
    idle(0);
    drain();

    ordy[1] = 1'b0;
    fork
      begin
        for (int j = 0; j < 4; j++) send(1, bp_d[j], 2'b00, bp_l[j]);
        idle(1);
      end
      begin
        repeat (6) @(posedge clk);
        #1 ordy[1] = 1'b1;
      end
    join
    drain();

    // eight more transfers push the 3-bit counter past its ceiling
    for (int m = 0; m < 4; m++) send(1, 18'h00F0, 2'(m), m0_l[m]);
    for (int m = 0; m < 4; m++) send(1, 18'h0FFFF, 2'(m), m1_l[m]);
    idle(1);
    drain();
    repeat (3) @(posedge clk);
    #1;

    ordy[1] = 1'b0;
    send(1, 18'h3C21, 2'b00, 8'hC);
    send(1, 18'h0F0F, 2'b00, 8'h0);
    idle(1);
    @(posedge clk);
    #2 reset = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    ordy[1] = 1'b1;
    send(1, 18'h00F0, 2'b01, 8'hF);
    idle(1);
    drain();

    send(2, 18'h030C3, 2'b00, 8'h0);
    send(2, 18'h000C3, 2'b00, 8'h3);
    send(2, 18'h3FFFF, 2'b11, 8'h3);
    idle(2);
    drain();

    repeat (2) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
